// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: splits byte/halfword/word accesses into big-endian
// single-byte transactions on a byte-wide synchronous data memory.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writeData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       mem_readData
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

  state_t            state_reg, state_next;
  logic              write_reg, signed_reg, mis_reg;
  logic [1:0]        size_reg, idx_reg, last_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg, acc_reg, rdata_reg;

  logic              refuse;
  logic              xfer;
  logic [1:0]        byte_sel;
  logic [7:0]        wr_byte;
  logic [31:0]       assembled;
  logic [31:0]       load_result;

  always_comb begin
    refuse = (req_size == 2'b11)
           | ((req_size == 2'b01) & req_addr[0])
           | ((req_size == 2'b10) & (|req_addr[1:0]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = refuse ? RESP : XFER;
      XFER:    if (idx_reg == last_reg) state_next = write_reg ? RESP : DRAIN;
      DRAIN:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte returned this cycle joins the accumulator at the low end.
  assign assembled = {acc_reg[23:0], mem_readData[7:0]};

  always_comb begin
    case (size_reg)
      2'b00:   load_result = {{24{assembled[7] & signed_reg}}, assembled[7:0]};
      2'b01:   load_result = {{16{assembled[15] & signed_reg}}, assembled[15:0]};
      default: load_result = assembled;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg  <= 1'b0;
      signed_reg <= 1'b0;
      mis_reg    <= 1'b0;
      size_reg   <= 2'b00;
      idx_reg    <= 2'b00;
      last_reg   <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      acc_reg    <= '0;
      rdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          write_reg  <= req_write;
          signed_reg <= req_signed;
          size_reg   <= req_size;
          addr_reg   <= req_addr;
          wdata_reg  <= req_wdata;
          idx_reg    <= 2'b00;
          last_reg   <= (req_size == 2'b00) ? 2'd0 : (req_size == 2'b01) ? 2'd1 : 2'd3;
          acc_reg    <= '0;
          mis_reg    <= refuse;
          if (refuse) rdata_reg <= '0;
        end
        XFER: begin
          idx_reg <= idx_reg + 2'd1;
          // Issue k's data arrives during issue k+1, so skip the first cycle.
          if (!write_reg && (idx_reg != 2'd0)) acc_reg <= assembled;
          if (write_reg && (idx_reg == last_reg)) rdata_reg <= '0;
        end
        DRAIN: rdata_reg <= load_result;
        default: ;
      endcase
    end
  end

  assign xfer       = (state_reg == XFER);
  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign misaligned = resp_valid & mis_reg;
  assign resp_rdata = rdata_reg;
  assign MemRead    = xfer & ~write_reg;
  assign MemWrite   = xfer & write_reg;

  assign mem_address = xfer ? (addr_reg + ADDR_W'(idx_reg)) : '0;

  // Most significant byte goes out first (lowest address).
  assign byte_sel = last_reg - idx_reg;

  always_comb begin
    case (byte_sel)
      2'd0:    wr_byte = wdata_reg[7:0];
      2'd1:    wr_byte = wdata_reg[15:8];
      2'd2:    wr_byte = wdata_reg[23:16];
      default: wr_byte = wdata_reg[31:24];
    endcase
  end

  assign mem_writeData = MemWrite ? {24'h0, wr_byte} : 32'h0;

endmodule
